// File: rtl/reg_window_file.sv
// SPARC-style integer register file with overlapping register windows, CWP/WIM and overflow/underflow traps.
// Define REG_WINDOW_BYPASS_EN to forward same-cycle rd writes to the read ports.
module reg_window_file #(
  parameter int unsigned NWINDOWS  = 8,
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CWPW      = 5,
  parameter int unsigned WIM_RESET = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                save,
  input  logic                restore,
  input  logic [CWPW-1:0]     cwp_in,
  input  logic                cwp_wr,
  output logic [CWPW-1:0]     cwp_out,
  output logic                cwp_wr_err,
  input  logic [NWINDOWS-1:0] wim_in,
  input  logic                wim_wr,
  output logic [NWINDOWS-1:0] wim_out,
  input  logic [4:0]          r1_sel,
  input  logic [4:0]          r2_sel,
  output logic [XLEN-1:0]     r1_out,
  output logic [XLEN-1:0]     r2_out,
  input  logic [4:0]          rd_sel,
  input  logic [XLEN-1:0]     rd_in,
  input  logic                rd_wr,
  input  logic                trap_ack,
  output logic                windows_overflow,
  output logic                windows_underflow,
  output logic [CWPW-1:0]     trap_cwp
);

  localparam int unsigned NPHYS = NWINDOWS * 16;
  localparam int unsigned IDXW  = $clog2(NPHYS);
  localparam int unsigned SW    = CWPW + 5;

  logic [XLEN-1:0] gregs [8];
  logic [XLEN-1:0] wregs [NPHYS];

  // Windowed register r8..r31 of window w; max sum is below 2*NPHYS so one fold suffices.
  function automatic logic [IDXW-1:0] phys_idx(input logic [CWPW-1:0] w, input logic [4:0] r);
    logic [SW-1:0] sum;
    sum = {1'b0, w, 4'b0000} + SW'(r) - SW'(8);
    if (sum >= SW'(NPHYS))
      sum = sum - SW'(NPHYS);
    return IDXW'(sum);
  endfunction

  logic [IDXW-1:0] r1_idx, r2_idx, rd_idx;
  logic            rd_en;

  assign r1_idx = phys_idx(cwp_out, r1_sel);
  assign r2_idx = phys_idx(cwp_out, r2_sel);
  assign rd_idx = phys_idx(cwp_out, rd_sel);
  assign rd_en  = rd_wr && (rd_sel != 5'd0);

`ifdef REG_WINDOW_BYPASS_EN
  logic byp1, byp2;
  assign byp1 = rd_en && ((rd_sel < 5'd8) ? (r1_sel == rd_sel)
                                          : ((r1_sel >= 5'd8) && (r1_idx == rd_idx)));
  assign byp2 = rd_en && ((rd_sel < 5'd8) ? (r2_sel == rd_sel)
                                          : ((r2_sel >= 5'd8) && (r2_idx == rd_idx)));
`endif

  always_comb begin
    r1_out = '0;
    if (r1_sel >= 5'd8)
      r1_out = wregs[r1_idx];
    else if (r1_sel != 5'd0)
      r1_out = gregs[r1_sel[2:0]];
`ifdef REG_WINDOW_BYPASS_EN
    if (byp1)
      r1_out = rd_in;
`endif
  end

  always_comb begin
    r2_out = '0;
    if (r2_sel >= 5'd8)
      r2_out = wregs[r2_idx];
    else if (r2_sel != 5'd0)
      r2_out = gregs[r2_sel[2:0]];
`ifdef REG_WINDOW_BYPASS_EN
    if (byp2)
      r2_out = rd_in;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 8; i++)
        gregs[i] <= '0;
      for (int unsigned i = 0; i < NPHYS; i++)
        wregs[i] <= '0;
    end else if (rd_en) begin
      if (rd_sel < 5'd8)
        gregs[rd_sel[2:0]] <= rd_in;
      else
        wregs[rd_idx] <= rd_in;
    end
  end

  logic [CWPW-1:0] save_nxt, rest_nxt;
  logic            save_hit, rest_hit, cwp_ok, move_ok;

  assign save_nxt = (cwp_out == '0) ? CWPW'(NWINDOWS - 1) : cwp_out - CWPW'(1);
  assign rest_nxt = (cwp_out == CWPW'(NWINDOWS - 1)) ? '0 : cwp_out + CWPW'(1);
  assign save_hit = |(wim_out & (NWINDOWS'(1) << save_nxt));
  assign rest_hit = |(wim_out & (NWINDOWS'(1) << rest_nxt));
  assign cwp_ok   = {1'b0, cwp_in} < (CWPW + 1)'(NWINDOWS);
  // trap_ack and CWP/WIM writes outrank window moves; they do not exclude each other.
  assign move_ok  = !trap_ack && !cwp_wr && !wim_wr && !windows_overflow &&
                    !windows_underflow && (save ^ restore);

  always_ff @(posedge clk) begin
    if (rst) begin
      cwp_out           <= '0;
      wim_out           <= NWINDOWS'(WIM_RESET);
      windows_overflow  <= 1'b0;
      windows_underflow <= 1'b0;
      trap_cwp          <= '0;
      cwp_wr_err        <= 1'b0;
    end else begin
      cwp_wr_err <= 1'b0;
      if (trap_ack) begin
        windows_overflow  <= 1'b0;
        windows_underflow <= 1'b0;
      end
      if (cwp_wr) begin
        if (cwp_ok)
          cwp_out <= cwp_in;
        else
          cwp_wr_err <= 1'b1;
      end
      if (wim_wr)
        wim_out <= wim_in;
      if (move_ok) begin
        if (save) begin
          if (save_hit) begin
            windows_overflow <= 1'b1;
            trap_cwp         <= cwp_out;
          end else begin
            cwp_out <= save_nxt;
          end
        end else begin
          if (rest_hit) begin
            windows_underflow <= 1'b1;
            trap_cwp          <= cwp_out;
          end else begin
            cwp_out <= rest_nxt;
          end
        end
      end
    end
  end

endmodule
